// File: rtl/split_arbiter_pkg.sv
// Shared types and encodings for the two-master split-transaction arbiter.
package split_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        OWN  = 2'd2
    } state_e;

    localparam logic [1:0] SLV_S1      = 2'd0;
    localparam logic [1:0] SLV_S2      = 2'd1;
    localparam logic [1:0] SLV_S3      = 2'd2;
    localparam logic [1:0] SLV_INVALID = 2'd3;

    localparam logic MASTER_M1 = 1'b0;
    localparam logic MASTER_M2 = 1'b1;

endpackage

// File: rtl/split_arbiter_tracker.sv
// Per-master park record: remembers which slave split this master off the
// bus and reports when that slave has released its split again.
module split_tracker
    import split_arbiter_pkg::*;
#(
    parameter int SLAVE_LEN = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        set,
    input  logic [SLAVE_LEN-1:0]        set_slave,
    input  logic                        clear,
    input  logic                        request,
    input  logic [(1<<SLAVE_LEN)-1:0]   split_en,
    output logic                        parked,
    output logic                        resume_ready
);

    logic [SLAVE_LEN-1:0] slave_q;

    // Park flag: explicit clear wins, then a new split, then a dropped request.
    always_ff @(posedge clk) begin
        if (reset) begin
            parked  <= 1'b0;
            slave_q <= SLV_S1;
        end else if (clear) begin
            parked <= 1'b0;
        end else if (set) begin
            parked  <= 1'b1;
            slave_q <= set_slave;
        end else if (!request) begin
            parked <= 1'b0;
        end
    end

    assign resume_ready = parked && !split_en[slave_q];

endmodule

// File: rtl/split_arbiter.sv
// Two-master bus arbiter with split parking and a hold-timeout watchdog.
//
// state | meaning
// IDLE  | no owner; wait for an eligible request
// ARB   | single arbitration cycle, winner latched on exit
// OWN   | winner holds the bus until done, split or watchdog
module split_arbiter
    import split_arbiter_pkg::*;
#(
    parameter int SLAVE_LEN = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m1_request,
    input  logic                 m2_request,
    input  logic [SLAVE_LEN-1:0] m1_slave_sel,
    input  logic [SLAVE_LEN-1:0] m2_slave_sel,
    input  logic                 trans_done,
    input  logic                 s1_split_en,
    input  logic                 s2_split_en,
    input  logic                 s3_split_en,
    output logic                 m1_grant,
    output logic                 m2_grant,
    output logic                 arbiter_busy,
    output logic                 bus_busy,
    output logic                 master_sel,
    output logic [SLAVE_LEN-1:0] slave_sel,
    output logic                 m1_split,
    output logic                 m2_split,
    output logic                 timeout
);

    localparam int NSLV = 1 << SLAVE_LEN;
    // Down-counter loaded with TIMEOUT-1 so terminal count lands on the last grant cycle.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_e          state;
    logic            last_winner;
    logic [TW-1:0]   timer;
    logic [NSLV-1:0] split_vec;

    logic m1_resume, m2_resume;
    logic m1_elig, m2_elig, m1_resuming, m2_resuming;
    logic winner, owning, ev_done, ev_split, ev_timeout;

    assign split_vec = {{(NSLV-3){1'b0}}, s3_split_en, s2_split_en, s1_split_en};

    // Eligibility, winner selection and ownership-ending events.
    always_comb begin
        m1_elig     = m1_request && (m1_slave_sel != SLV_INVALID) && (!m1_split || m1_resume);
        m2_elig     = m2_request && (m2_slave_sel != SLV_INVALID) && (!m2_split || m2_resume);
        m1_resuming = m1_elig && m1_split;
        m2_resuming = m2_elig && m2_split;
        if (m1_resuming != m2_resuming)
            winner = m1_resuming ? MASTER_M1 : MASTER_M2;
        else if (m1_elig && m2_elig)
            winner = ~last_winner;
        else
            winner = m1_elig ? MASTER_M1 : MASTER_M2;
        owning     = (state == OWN);
        ev_done    = owning && trans_done;
        ev_split   = owning && !trans_done && split_vec[slave_sel];
        ev_timeout = owning && !trans_done && !split_vec[slave_sel] &&
                     (TIMEOUT != 0) && (timer == '0);
    end

    split_tracker #(.SLAVE_LEN(SLAVE_LEN)) u_trk_m1 (
        .clk          (clk),
        .reset        (reset),
        .set          (ev_split && (master_sel == MASTER_M1)),
        .set_slave    (slave_sel),
        .clear        ((ev_done || ev_timeout) && (master_sel == MASTER_M1)),
        .request      (m1_request),
        .split_en     (split_vec),
        .parked       (m1_split),
        .resume_ready (m1_resume)
    );

    split_tracker #(.SLAVE_LEN(SLAVE_LEN)) u_trk_m2 (
        .clk          (clk),
        .reset        (reset),
        .set          (ev_split && (master_sel == MASTER_M2)),
        .set_slave    (slave_sel),
        .clear        ((ev_done || ev_timeout) && (master_sel == MASTER_M2)),
        .request      (m2_request),
        .split_en     (split_vec),
        .parked       (m2_split),
        .resume_ready (m2_resume)
    );

    // Sequencer with registered grant, select and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_winner  <= MASTER_M2;
            timer        <= '0;
            m1_grant     <= 1'b0;
            m2_grant     <= 1'b0;
            arbiter_busy <= 1'b0;
            bus_busy     <= 1'b0;
            master_sel   <= MASTER_M1;
            slave_sel    <= '0;
            timeout      <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (m1_elig || m2_elig) begin
                        state        <= ARB;
                        arbiter_busy <= 1'b1;
                    end
                end
                ARB: begin
                    arbiter_busy <= 1'b0;
                    if (m1_elig || m2_elig) begin
                        state       <= OWN;
                        master_sel  <= winner;
                        slave_sel   <= (winner == MASTER_M2) ? m2_slave_sel : m1_slave_sel;
                        last_winner <= winner;
                        m1_grant    <= (winner == MASTER_M1);
                        m2_grant    <= (winner == MASTER_M2);
                        bus_busy    <= 1'b1;
                        timer       <= TMR_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                OWN: begin
                    if (ev_done || ev_split || ev_timeout) begin
                        state    <= IDLE;
                        m1_grant <= 1'b0;
                        m2_grant <= 1'b0;
                        bus_busy <= 1'b0;
                        timeout  <= ev_timeout;
                    end else if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_split_arbiter.sv
// Bench for split_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_split_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m1_request = 1'b0, m2_request = 1'b0;
    logic [1:0] m1_slave_sel = 2'd0, m2_slave_sel = 2'd0;
    logic       trans_done = 1'b0;
    logic       s1_split_en = 1'b0, s2_split_en = 1'b0, s3_split_en = 1'b0;
    logic       m1_grant, m2_grant, arbiter_busy, bus_busy, master_sel;
    logic [1:0] slave_sel;
    logic       m1_split, m2_split, timeout;

    always #5 clk = ~clk;

    split_arbiter #(.SLAVE_LEN(2), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m1_request(m1_request), .m2_request(m2_request),
        .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
        .trans_done(trans_done),
        .s1_split_en(s1_split_en), .s2_split_en(s2_split_en), .s3_split_en(s3_split_en),
        .m1_grant(m1_grant), .m2_grant(m2_grant),
        .arbiter_busy(arbiter_busy), .bus_busy(bus_busy),
        .master_sel(master_sel), .slave_sel(slave_sel),
        .m1_split(m1_split), .m2_split(m2_split), .timeout(timeout)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: who owns the bus, how long, and who is parked where.
    int         m_own;
    int         m_held;
    int         m_last;
    int         m_pslv [2];
    bit         m_arb;
    bit         m_park [2];
    bit         m_to;
    logic       m_msel;
    logic [1:0] m_ssel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [9:0] dut_vec();
        return {m1_grant, m2_grant, arbiter_busy, bus_busy, master_sel, slave_sel,
                m1_split, m2_split, timeout};
    endfunction

    function automatic logic [9:0] model_vec();
        return {m_own == 0, m_own == 1, m_arb, m_own >= 0, m_msel, m_ssel,
                m_park[0], m_park[1], m_to};
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_next();
        bit         req [2];
        logic [1:0] sel [2];
        bit         spl [3];
        bit         elig [2];
        bit         res [2];
        bit         touched [2];
        int         w;
        int         o;
        req[0] = m1_request;   req[1] = m2_request;
        sel[0] = m1_slave_sel; sel[1] = m2_slave_sel;
        spl[0] = s1_split_en;  spl[1] = s2_split_en; spl[2] = s3_split_en;
        m_to = 1'b0;
        if (reset) begin
            m_own = -1; m_held = 0; m_last = 1; m_arb = 1'b0;
            m_park[0] = 1'b0; m_park[1] = 1'b0; m_pslv[0] = 0; m_pslv[1] = 0;
            m_msel = 1'b0; m_ssel = 2'd0;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            elig[i]    = req[i] && (sel[i] != 2'b11) && (!m_park[i] || !spl[m_pslv[i]]);
            res[i]     = elig[i] && m_park[i];
            touched[i] = 1'b0;
        end
        if (m_arb) begin
            m_arb = 1'b0;
            if (elig[0] || elig[1]) begin
                if (res[0] != res[1])       w = res[0] ? 0 : 1;
                else if (elig[0] && elig[1]) w = (m_last == 0) ? 1 : 0;
                else                         w = elig[0] ? 0 : 1;
                m_own  = w;
                m_held = 1;
                m_last = w;
                m_msel = (w == 1);
                m_ssel = sel[w];
            end
        end else if (m_own < 0) begin
            if (elig[0] || elig[1]) m_arb = 1'b1;
        end else begin
            o = m_own;
            if (trans_done) begin
                m_park[o] = 1'b0; touched[o] = 1'b1; m_own = -1;
            end else if (spl[m_ssel]) begin
                m_park[o] = 1'b1; m_pslv[o] = int'(m_ssel); touched[o] = 1'b1; m_own = -1;
            end else if (TO != 0 && m_held == TO) begin
                m_to = 1'b1; m_park[o] = 1'b0; touched[o] = 1'b1; m_own = -1;
            end else begin
                m_held++;
            end
        end
        for (int i = 0; i < 2; i++)
            if (!touched[i] && m_park[i] && !req[i]) m_park[i] = 1'b0;
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        cyc++;
        chk("outputs", 32'(dut_vec()), 32'(model_vec()));
    endtask

    initial begin
        int cnt;

        // Reset
        step(); step();
        chk("reset_state", 32'(dut_vec()), 32'd0);
        reset = 1'b0;
        step();

        // Tie after reset: m1, then m2, then m1 again
        m1_request = 1'b1; m1_slave_sel = 2'd0;
        m2_request = 1'b1; m2_slave_sel = 2'd2;
        step(); chk("tie_arb", 32'(arbiter_busy), 32'd1);
        step(); chk("tie_first_m1", 32'(m1_grant), 32'd1);
        trans_done = 1'b1; m1_request = 1'b0;
        step(); chk("tie_gap_idle", 32'(bus_busy), 32'd0);
        trans_done = 1'b0;
        step(); chk("tie_second_arb", 32'(arbiter_busy), 32'd1);
        step(); chk("tie_second_m2", 32'(m2_grant), 32'd1);
        trans_done = 1'b1; m2_request = 1'b0;
        step();
        trans_done = 1'b0;
        m1_request = 1'b1; m2_request = 1'b1;
        step(); step(); chk("tie_third_m1", 32'(m1_grant), 32'd1);
        trans_done = 1'b1; m1_request = 1'b0; m2_request = 1'b0;
        step();
        trans_done = 1'b0;
        step();

        // Single request latency, trans_done on the would-be timeout cycle
        m1_request = 1'b1; m1_slave_sel = 2'd1;
        step(); chk("single_arb", 32'(arbiter_busy), 32'd1);
        step(); chk("single_grant", 32'({m1_grant, slave_sel}), 32'b101);
        step(); step(); step();
        trans_done = 1'b1; m1_request = 1'b0;
        step(); chk("single_release", 32'({m1_grant, bus_busy, timeout}), 32'd0);
        trans_done = 1'b0;
        step();

        // Split on s3, m2 served, m1 resumes ahead of pending m2
        m1_request = 1'b1; m1_slave_sel = 2'd2;
        step(); step(); chk("split_m1_owns", 32'(m1_grant), 32'd1);
        m2_request = 1'b1; m2_slave_sel = 2'd0; s3_split_en = 1'b1;
        step(); chk("split_parked", 32'({m1_split, m1_grant}), 32'b10);
        step(); step(); chk("split_m2_owns", 32'(m2_grant), 32'd1);
        s3_split_en = 1'b0;
        step();
        trans_done = 1'b1;
        step();
        trans_done = 1'b0;
        step(); step(); chk("split_resume_m1", 32'({m1_grant, m2_grant}), 32'b10);
        trans_done = 1'b1; m1_request = 1'b0;
        step(); chk("split_flag_cleared", 32'(m1_split), 32'd0);
        trans_done = 1'b0;
        step(); step();
        trans_done = 1'b1; m2_request = 1'b0;
        step();
        trans_done = 1'b0;
        step();

        // Watchdog
        m1_request = 1'b1; m1_slave_sel = 2'd0;
        step(); step();
        m2_request = 1'b1; m2_slave_sel = 2'd1;
        cnt = 0;
        while (m1_grant && cnt < 20) begin
            cnt++;
            step();
        end
        chk("wd_grant_len", 32'(cnt), 32'(TO));
        chk("wd_pulse", 32'({timeout, m1_split}), 32'b10);
        m1_request = 1'b0;
        step(); step(); chk("wd_next_m2", 32'(m2_grant), 32'd1);
        trans_done = 1'b1; m2_request = 1'b0;
        step();
        trans_done = 1'b0;
        step();

        // trans_done and split together: no park
        m1_request = 1'b1; m1_slave_sel = 2'd1;
        step(); step();
        s2_split_en = 1'b1; trans_done = 1'b1; m1_request = 1'b0;
        step(); chk("done_beats_split", 32'({m1_split, m1_grant}), 32'd0);
        s2_split_en = 1'b0; trans_done = 1'b0;
        step();

        // Invalid slave select never granted
        m2_request = 1'b1; m2_slave_sel = 2'b11;
        for (int i = 0; i < 6; i++) step();
        chk("invalid_sel", 32'({m2_grant, bus_busy, arbiter_busy}), 32'd0);
        m2_request = 1'b0;
        step();

        // Parked master drops its request
        m1_request = 1'b1; m1_slave_sel = 2'd0;
        step(); step();
        s1_split_en = 1'b1;
        step(); chk("drop_parked", 32'(m1_split), 32'd1);
        m1_request = 1'b0;
        step(); chk("drop_cleared", 32'(m1_split), 32'd0);
        s1_split_en = 1'b0;
        step();

        // Reset while m2 owns and m1 is parked
        m1_request = 1'b1; m1_slave_sel = 2'd0;
        step(); step();
        s1_split_en = 1'b1;
        step();
        m2_request = 1'b1; m2_slave_sel = 2'd2;
        step(); step(); chk("pre_reset_own", 32'({m2_grant, m1_split}), 32'b11);
        reset = 1'b1;
        step(); chk("mid_own_reset", 32'(dut_vec()), 32'd0);
        reset = 1'b0; m1_request = 1'b0; m2_request = 1'b0; s1_split_en = 1'b0;
        step();

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) m1_request = ~m1_request;
            if ($urandom_range(0, 3) == 0) m2_request = ~m2_request;
            if ($urandom_range(0, 5) == 0)
                m1_slave_sel = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0)
                m2_slave_sel = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            trans_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) s1_split_en = ~s1_split_en;
            if ($urandom_range(0, 7) == 0) s2_split_en = ~s2_split_en;
            if ($urandom_range(0, 7) == 0) s3_split_en = ~s3_split_en;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
